keypad_bcd_entry: RTL and testbench

Input-side counterpart to the 7-segment display driver. It scans a 4x4 matrix keypad by driving one active-low column at a time and reading active-low rows. Each key press is debounced, decoded to a 4-bit key code and applied to a 3-digit BCD entry register. The entry register feeds the display path, and the keypad events feed the calculator control FSM.

---
 rtl/keypad_bcd_entry.sv | 221 ++++++++++++++++++++++
 tb/tb_keypad_bcd_entry.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with debounce, key decode and a 3-digit BCD entry register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_bcd_entry #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_TICKS   = 50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_ce,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_drive,
    output logic [11:0] o_bcd,
    output logic [3:0]  o_key,
    output logic        o_valid
);

    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_TICKS + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_bcd_entry: parameter out of range");
    end

    typedef enum logic [1:0] {StScan, StDebounce, StHold} state_t;

    state_t              state;
    logic [3:0]          row_meta;
    logic [3:0]          row_sync;
    logic [TICK_W-1:0]   tick_cnt;
    logic [1:0]          col_idx;
    logic [DEB_W-1:0]    deb_cnt;
    logic [DEB_W-1:0]    rel_cnt;
    logic [3:0]          cand;
    logic                tick;
    logic                key_found;
    logic [1:0]          row_idx;
    logic [3:0]          key_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0]    rep_cnt;
`endif

    function automatic logic [3:0] col_dec(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Digits shift in from the right; B is backspace, C clears, operators leave the entry alone.
    function automatic logic [11:0] bcd_next(input logic [11:0] bcd, input logic [3:0] code);
        logic [11:0] res;
        res = bcd;
        if (code <= 4'd9) begin
            res = {bcd[7:0], code};
        end else if (code == 4'hB) begin
            res = {4'h0, bcd[11:4]};
        end else if (code == 4'hC) begin
            res = 12'h000;
        end
        return res;
    endfunction

    assign tick = i_ce && (tick_cnt == TICK_W'(SCAN_DIV - 1));

    // Exactly one low row is a key; none or several low rows count as no key.
    always_comb begin
        key_found = 1'b1;
        row_idx   = 2'd0;
        case (row_sync)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: key_found = 1'b0;
        endcase
        key_code = key_lut(row_idx, col_idx);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= StScan;
            tick_cnt  <= '0;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            cand      <= 4'h0;
            col_drive <= 4'b1111;
            o_bcd     <= 12'h000;
            o_key     <= 4'h0;
            o_valid   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            if (!i_ce) begin
                state     <= StScan;
                tick_cnt  <= '0;
                deb_cnt   <= '0;
                rel_cnt   <= '0;
                col_drive <= 4'b1111;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
            end else begin
                col_drive <= col_dec(col_idx);
                tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    case (state)
                        StScan: begin
                            if (key_found) begin
                                cand    <= key_code;
                                deb_cnt <= DEB_W'(1);
                                if (DEBOUNCE_TICKS == 1) begin
                                    o_valid <= 1'b1;
                                    o_key   <= key_code;
                                    o_bcd   <= bcd_next(o_bcd, key_code);
                                    rel_cnt <= '0;
                                    state   <= StHold;
`ifdef KEYPAD_AUTOREPEAT_EN
                                    rep_cnt <= '0;
`endif
                                end else begin
                                    state <= StDebounce;
                                end
                            end else begin
                                col_idx   <= col_idx + 2'd1;
                                col_drive <= col_dec(col_idx + 2'd1);
                            end
                        end
                        StDebounce: begin
                            if (key_found && key_code == cand) begin
                                deb_cnt <= deb_cnt + 1'b1;
                                if (deb_cnt == DEB_W'(DEBOUNCE_TICKS - 1)) begin
                                    o_valid <= 1'b1;
                                    o_key   <= cand;
                                    o_bcd   <= bcd_next(o_bcd, cand);
                                    rel_cnt <= '0;
                                    state   <= StHold;
`ifdef KEYPAD_AUTOREPEAT_EN
                                    rep_cnt <= '0;
`endif
                                end
                            end else begin
                                state     <= StScan;
                                deb_cnt   <= '0;
                                col_idx   <= col_idx + 2'd1;
                                col_drive <= col_dec(col_idx + 2'd1);
                            end
                        end
                        StHold: begin
                            // Any key on the frozen column, even a different one, keeps the hold.
                            if (key_found) begin
                                rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                if (key_code == cand) begin
                                    if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
                                        rep_cnt <= '0;
                                        o_valid <= 1'b1;
                                        o_key   <= cand;
                                        o_bcd   <= bcd_next(o_bcd, cand);
                                    end else begin
                                        rep_cnt <= rep_cnt + 1'b1;
                                    end
                                end
`endif
                            end else if (rel_cnt == DEB_W'(DEBOUNCE_TICKS - 1)) begin
                                state     <= StScan;
                                rel_cnt   <= '0;
                                deb_cnt   <= '0;
                                col_idx   <= col_idx + 2'd1;
                                col_drive <= col_dec(col_idx + 2'd1);
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt   <= '0;
`endif
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end
                        default: state <= StScan;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry: a behavioural keypad matrix feeds row_in from col_drive.
module tb_keypad_bcd_entry;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_ce = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_drive;
    logic [11:0] o_bcd;
    logic [3:0]  o_key;
    logic        o_valid;

    logic [15:0] keys = '0;   // bit r*4+c set = key at row r, column c held down
    int          vectors = 0;
    int          miscompares = 0;
    int          valid_cnt = 0;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [11:0] T6_BCD0 = 12'h777;
    localparam logic [11:0] T6_BCD1 = 12'h772;
`else
    localparam logic [11:0] T6_BCD0 = 12'h005;
    localparam logic [11:0] T6_BCD1 = 12'h052;
`endif

    keypad_bcd_entry #(
        .SCAN_DIV      (4),
        .DEBOUNCE_TICKS(3),
        .REPEAT_TICKS  (5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .i_ce     (i_ce),
        .row_in   (row_in),
        .col_drive(col_drive),
        .o_bcd    (o_bcd),
        .o_key    (o_key),
        .o_valid  (o_valid)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_drive[c]) row_in[r] = 1'b0;
            end
        end
    end

    always @(posedge CLK) if (o_valid === 1'b1) valid_cnt <= valid_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_drive(input logic [3:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge CLK);
            if (col_drive === v) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            if (o_valid === 1'b1) seen = 1'b1;
        end
    endtask

    // Press, wait for the event, check it, then release fully.
    task automatic press_key(input string tag, input int r, input int c,
                             input logic [3:0] exp_key, input logic [11:0] exp_bcd);
        int v0;
        bit seen;
        v0 = valid_cnt;
        keys = '0;
        keys[r*4+c] = 1'b1;
        wait_valid(seen);
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_key"}, 32'(o_key), 32'(exp_key));
        check({tag, "_bcd"}, 32'(o_bcd), 32'(exp_bcd));
        @(negedge CLK);
        check({tag, "_pulse"}, 32'(o_valid), 32'd0);
        keys = '0;
        repeat (40) @(negedge CLK);
        check({tag, "_count"}, 32'(valid_cnt), 32'(v0 + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        int v0;
        logic [3:0] exp_col;

        // 1: reset values, then free-running scan
        repeat (3) @(negedge CLK);
        check("rst_col", 32'(col_drive), 32'h0000000F);
        check("rst_bcd", 32'(o_bcd), 32'h0);
        check("rst_key", 32'(o_key), 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        RST = 1'b0;
        i_ce = 1'b1;
        wait_drive(4'b1101, ok);
        check("t1_reach_col1", 32'(ok), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            exp_col = ~(4'b0001 << ((1 + i / 4) % 4));
            check($sformatf("t1_col_%0d", i), 32'(col_drive), 32'(exp_col));
        end
        check("t1_no_valid", 32'(valid_cnt), 32'd0);
        check("t1_bcd", 32'(o_bcd), 32'h0);

        // 2: key 2 pressed while column 1 is driven, then release resumes at column 2
        v0 = valid_cnt;
        wait_drive(4'b1101, ok);
        check("t2_reach_col1", 32'(ok), 32'd1);
        keys = 16'h0002;
        wait_valid(seen);
        check("t2_seen", 32'(seen), 32'd1);
        check("t2_key", 32'(o_key), 32'h2);
        check("t2_bcd", 32'(o_bcd), 32'h002);
        @(negedge CLK);
        check("t2_pulse", 32'(o_valid), 32'd0);
        check("t2_frozen", 32'(col_drive), 32'b1101);
        keys = '0;
        for (int i = 0; i < 100 && col_drive === 4'b1101; i++) @(negedge CLK);
        check("t2_resume", 32'(col_drive), 32'b1011);
        check("t2_count", 32'(valid_cnt), 32'(v0 + 1));

        // 3: digit entry, backspace, clear
        press_key("t3_clr0", 2, 3, 4'hC, 12'h000);
        press_key("t3_k1", 0, 0, 4'h1, 12'h001);
        press_key("t3_k2", 0, 1, 4'h2, 12'h012);
        press_key("t3_k3", 0, 2, 4'h3, 12'h123);
        press_key("t3_k4", 1, 0, 4'h4, 12'h234);
        press_key("t3_bs", 1, 3, 4'hB, 12'h023);
        press_key("t3_clr", 2, 3, 4'hC, 12'h000);

        // 4: bounce (2 good ticks, then a gap) yields nothing until a clean press
        v0 = valid_cnt;
        wait_drive(4'b1101, ok);
        check("t4_reach_col1", 32'(ok), 32'd1);
        keys = 16'h0020;
        repeat (8) @(negedge CLK);
        keys = '0;
        repeat (4) @(negedge CLK);
        check("t4_bounce_none", 32'(valid_cnt), 32'(v0));
        press_key("t4_k5", 1, 1, 4'h5, 12'h005);
        check("t4_one_event", 32'(valid_cnt), 32'(v0 + 1));
        // two rows low in one column is not a key
        v0 = valid_cnt;
        keys = 16'h0022;
        repeat (60) @(negedge CLK);
        keys = '0;
        repeat (40) @(negedge CLK);
        check("t4_multi_none", 32'(valid_cnt), 32'(v0));
        check("t4_multi_bcd", 32'(o_bcd), 32'h005);

        // 5: operator keys leave the entry alone
        press_key("t5_A", 0, 3, 4'hA, 12'h005);
        press_key("t5_E", 3, 2, 4'hE, 12'h005);

`ifdef KEYPAD_AUTOREPEAT_EN
        press_key("t5_clr", 2, 3, 4'hC, 12'h000);
        v0 = valid_cnt;
        keys = 16'h0100;
        for (int i = 0; i < 400 && valid_cnt < v0 + 3; i++) @(negedge CLK);
        check("t5_rep_count", 32'(valid_cnt), 32'(v0 + 3));
        check("t5_rep_bcd", 32'(o_bcd), 32'h777);
        keys = '0;
        repeat (40) @(negedge CLK);
`endif

        // 6: i_ce dropped mid-debounce, then reset during hold
        v0 = valid_cnt;
        wait_drive(4'b1101, ok);
        check("t6_reach_col1", 32'(ok), 32'd1);
        keys = 16'h0002;
        repeat (6) @(negedge CLK);
        i_ce = 1'b0;
        @(negedge CLK);
        check("t6_off_col", 32'(col_drive), 32'b1111);
        check("t6_off_valid", 32'(o_valid), 32'd0);
        repeat (20) @(negedge CLK);
        check("t6_off_count", 32'(valid_cnt), 32'(v0));
        check("t6_off_bcd", 32'(o_bcd), 32'(T6_BCD0));
        i_ce = 1'b1;
        @(negedge CLK);
        check("t6_resume_col", 32'(col_drive), 32'b1101);
        wait_valid(seen);
        check("t6_seen", 32'(seen), 32'd1);
        check("t6_key", 32'(o_key), 32'h2);
        check("t6_bcd", 32'(o_bcd), 32'(T6_BCD1));
        repeat (6) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("t6_rst_col", 32'(col_drive), 32'b1111);
        check("t6_rst_bcd", 32'(o_bcd), 32'h000);
        check("t6_rst_key", 32'(o_key), 32'h0);
        check("t6_rst_valid", 32'(o_valid), 32'd0);
        keys = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        check("t6_post_count", 32'(valid_cnt), 32'(v0 + 1));
        check("t6_post_bcd", 32'(o_bcd), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
